// File: rtl/stpm_cmd_sched.sv
// stpm_cmd_sched: keypad-token command parser, command FIFO and run sequencer
// placed in front of stpm_full. Each accepted command "<motor> SPACE <dir>
// <1-3 digits> ENTER" becomes {motor, dir, cycles} and is replayed as a timed
// active-low enable window followed by an all-off gap.
// Optional build macro STPM_CMD_ABORT_EN: token 14 becomes an abort that
// flushes the queue, resets the parser and cuts the current run short.
module stpm_cmd_sched #(
    parameter int STEP_NUM        = 71,
    parameter int STEP_SHIFT      = 7,
    parameter int MAX_DEG         = 360,
    parameter int TICKS_PER_CYCLE = 1000,
    parameter int GAP_TICKS       = 100,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Data,
    input  logic       i_Ena,
    output logic       o_Dir,
    output logic [3:0] o_En,
    output logic [9:0] o_Cycles,
    output logic       o_Busy,
    output logic       o_Err,
    output logic [2:0] o_Count
);

    localparam logic [3:0] TOK_SPACE = 4'd10;
    localparam logic [3:0] TOK_ENTER = 4'd11;
    localparam logic [3:0] TOK_FWD   = 4'd12;
    localparam logic [3:0] TOK_BWD   = 4'd13;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TMR_W = $clog2(1024 * TICKS_PER_CYCLE + 1);
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {P_MOTOR, P_SEP, P_DIR, P_DEG} pstate_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_GAP} sstate_t;

    pstate_t          r_PState, w_PNext;
    sstate_t          r_SState, w_SNext;
    logic [1:0]       r_Motor, r_CurMotor;
    logic             r_PDir, r_Dir;
    logic [9:0]       r_Deg, r_Cycles;
    logic [1:0]       r_DigCnt;
    logic             r_PushVld, r_Err;
    logic [12:0]      r_Mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_Wp, r_Rp;
    logic [2:0]       r_Count;
    logic [TMR_W-1:0] r_Timer;
    logic [GAP_W-1:0] r_Gap;
    logic             w_Abort, w_PErr, w_LatchMotor, w_LatchDir, w_AddDigit, w_PushReq;
    logic             w_Full, w_Wr, w_Drop, w_Pop;

    // Degrees to motor cycles: 18-bit product, shifted, truncated to 10 bits
    function automatic logic [9:0] f_deg2cyc(input logic [9:0] deg);
        logic [17:0] prod;
        prod = 18'(deg) * 18'(STEP_NUM);
        return 10'(prod >> STEP_SHIFT);
    endfunction

`ifdef STPM_CMD_ABORT_EN
    assign w_Abort = i_Ena && (i_Data == 4'd14);
`else
    assign w_Abort = 1'b0;
`endif

    assign w_Full = (r_Count == 3'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the sequencer pops in the same clock
    assign w_Wr   = r_PushVld && (!w_Full || w_Pop) && !w_Abort;
    assign w_Drop = r_PushVld && w_Full && !w_Pop && !w_Abort;

    // Parser next state: any token not legal in the current state is rejected
    always_comb begin
        w_PNext      = r_PState;
        w_PErr       = 1'b0;
        w_LatchMotor = 1'b0;
        w_LatchDir   = 1'b0;
        w_AddDigit   = 1'b0;
        w_PushReq    = 1'b0;
        if (w_Abort) begin
            w_PNext = P_MOTOR;
        end else if (i_Ena) begin
            w_PErr  = 1'b1;
            w_PNext = P_MOTOR;
            case (r_PState)
                P_MOTOR: if (i_Data >= 4'd1 && i_Data <= 4'd4) begin
                    w_PErr = 1'b0; w_LatchMotor = 1'b1; w_PNext = P_SEP;
                end
                P_SEP: if (i_Data == TOK_SPACE) begin
                    w_PErr = 1'b0; w_PNext = P_DIR;
                end
                P_DIR: if (i_Data == TOK_FWD || i_Data == TOK_BWD) begin
                    w_PErr = 1'b0; w_LatchDir = 1'b1; w_PNext = P_DEG;
                end
                P_DEG: begin
                    if (i_Data <= 4'd9 && r_DigCnt != 2'd3) begin
                        w_PErr = 1'b0; w_AddDigit = 1'b1; w_PNext = P_DEG;
                    end else if (i_Data == TOK_ENTER && r_DigCnt != 2'd0 &&
                                 r_Deg <= 10'(MAX_DEG)) begin
                        w_PErr = 1'b0; w_PushReq = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Parser control state, push request stage and error pulse
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_PState  <= P_MOTOR;
            r_DigCnt  <= 2'd0;
            r_PushVld <= 1'b0;
            r_Err     <= 1'b0;
        end else begin
            r_PState  <= w_PNext;
            r_PushVld <= w_PushReq;
            r_Err     <= w_PErr || w_Drop;
            if (w_LatchDir)      r_DigCnt <= 2'd0;
            else if (w_AddDigit) r_DigCnt <= r_DigCnt + 2'd1;
        end
    end

    // Parser command fields; still stable when the push lands one clock after ENTER
    always_ff @(posedge i_Clk) begin
        if (w_LatchMotor) r_Motor <= 2'(i_Data - 4'd1);
        if (w_LatchDir) begin
            r_PDir <= (i_Data == TOK_BWD);
            r_Deg  <= 10'd0;
        end else if (w_AddDigit) begin
            r_Deg <= (r_Deg * 10'd10) + {6'd0, i_Data};
        end
    end

    // FIFO storage; cycles are computed as the entry is written
    always_ff @(posedge i_Clk) begin
        if (w_Wr) r_Mem[r_Wp] <= {r_Motor, r_PDir, f_deg2cyc(r_Deg)};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Wp <= '0; r_Rp <= '0; r_Count <= 3'd0;
        end else if (w_Abort) begin
            r_Wp <= '0; r_Rp <= '0; r_Count <= 3'd0;
        end else begin
            if (w_Wr)  r_Wp <= r_Wp + 1'b1;
            if (w_Pop) r_Rp <= r_Rp + 1'b1;
            if (w_Wr && !w_Pop)      r_Count <= r_Count + 3'd1;
            else if (!w_Wr && w_Pop) r_Count <= r_Count - 3'd1;
        end
    end

    // Sequencer next state and pop request
    always_comb begin
        w_SNext = r_SState;
        w_Pop   = 1'b0;
        case (r_SState)
            S_IDLE: if (r_Count != 3'd0 && !w_Abort) begin
                w_Pop = 1'b1; w_SNext = S_LOAD;
            end
            S_LOAD: w_SNext = (w_Abort || r_Cycles == 10'd0) ? S_GAP : S_RUN;
            S_RUN:  if (w_Abort || r_Timer == TMR_W'(1)) w_SNext = S_GAP;
            S_GAP:  if (r_Gap == GAP_W'(1)) w_SNext = S_IDLE;
            default: w_SNext = S_IDLE;
        endcase
    end

    // Sequencer state, current command and run/gap timers
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_SState   <= S_IDLE;
            r_CurMotor <= 2'd0;
            r_Dir      <= 1'b0;
            r_Cycles   <= 10'd0;
            r_Timer    <= '0;
            r_Gap      <= '0;
        end else begin
            r_SState <= w_SNext;
            if (w_Pop) {r_CurMotor, r_Dir, r_Cycles} <= r_Mem[r_Rp];
            if (r_SState == S_LOAD)     r_Timer <= TMR_W'(r_Cycles) * TMR_W'(TICKS_PER_CYCLE);
            else if (r_SState == S_RUN) r_Timer <= r_Timer - 1'b1;
            if (w_SNext == S_GAP && r_SState != S_GAP) r_Gap <= GAP_W'(GAP_TICKS);
            else if (r_SState == S_GAP)                r_Gap <= r_Gap - 1'b1;
        end
    end

    // Enable decode: only S_RUN drives a motor, so reset releases it at once
    always_comb begin
        o_En = 4'b1111;
        if (r_SState == S_RUN) o_En = ~(4'b0001 << r_CurMotor);
    end

    assign o_Dir    = r_Dir;
    assign o_Cycles = r_Cycles;
    assign o_Busy   = (r_SState != S_IDLE);
    assign o_Err    = r_Err;
    assign o_Count  = r_Count;

endmodule

// File: tb/tb_stpm_cmd_sched.sv
// Bench for stpm_cmd_sched (TICKS_PER_CYCLE=4, GAP_TICKS=2). Expected enable
// runs are queued as commands are issued; a monitor measures every run the
// DUT produces and checks it against the head of that queue.
module tb_stpm_cmd_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_Data;
    logic       i_Ena;
    logic       w_Dir, w_Busy, w_Err;
    logic [3:0] w_En;
    logic [9:0] w_Cycles;
    logic [2:0] w_Count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int err_cnt  = 0;

    typedef struct {
        logic [3:0] en;
        logic       dir;
        logic [9:0] cycles;
        int         len;
        int         lat_kind;   // 0 none, 1 from ENTER, 2 from previous run end
        int         lat;
    } run_t;
    run_t exp_q[$];

    stpm_cmd_sched #(.TICKS_PER_CYCLE(4), .GAP_TICKS(2)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_Data(i_Data), .i_Ena(i_Ena),
        .o_Dir(w_Dir), .o_En(w_En), .o_Cycles(w_Cycles),
        .o_Busy(w_Busy), .o_Err(w_Err), .o_Count(w_Count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measures enable runs and counts error pulses
    initial begin
        bit         in_run = 0;
        logic [3:0] r_en = 4'hF;
        logic       r_dir = 0;
        logic [9:0] r_cyc = 0;
        int r_len = 0, lat1 = 0, lat2 = 0, enter_cyc = 0, last_end = 0;
        run_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_run = 0;
            end else begin
                if (i_Ena && i_Data == 4'd11) enter_cyc = cyc + 1;
                if (w_Err) err_cnt++;
                if (!in_run && w_En != 4'hF) begin
                    in_run = 1; r_en = w_En; r_dir = w_Dir; r_cyc = w_Cycles; r_len = 0;
                    lat1 = cyc - enter_cyc; lat2 = cyc - last_end;
                end
                if (in_run) begin
                    if (w_En == r_en) r_len++;
                    else begin
                        in_run = 0; last_end = cyc;
                        if (exp_q.size() == 0) begin
                            check("unexpected_run_en", r_en, 4'hF);
                        end else begin
                            e = exp_q.pop_front();
                            check("run_en", r_en, e.en);
                            check("run_dir", r_dir, e.dir);
                            check("run_cycles", r_cyc, e.cycles);
                            check("run_len", r_len, e.len);
                            if (e.lat_kind == 1) check("run_lat_enter", lat1, e.lat);
                            if (e.lat_kind == 2) check("run_gap", lat2, e.lat);
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tok(input int d);
        i_Data = 4'(d); i_Ena = 1'b1;
        step(1);
        i_Ena = 1'b0;
    endtask

    task automatic cmd(input int m, input int dtok, input int deg, input int nd);
        tok(m); tok(10); tok(dtok);
        if (nd >= 3) tok(deg / 100);
        if (nd >= 2) tok((deg / 10) % 10);
        if (nd >= 1) tok(deg % 10);
        tok(11);
    endtask

    task automatic push_run(input logic [3:0] en, input logic dir, input logic [9:0] c,
                            input int len, input int kind, input int lat);
        run_t e;
        e.en = en; e.dir = dir; e.cycles = c; e.len = len; e.lat_kind = kind; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int maxc);
        int i = 0;
        while ((exp_q.size() != 0 || w_Busy) && i < maxc) begin step(1); i++; end
        check(name, (exp_q.size() == 0 && !w_Busy), 1);
    endtask

    task automatic err_tok_check(input string name, input int e0);
        step(3);
        check(name, err_cnt - e0, 1);
    endtask

    initial begin
        int e0, bc;
        rst_n = 1'b0; i_Data = 4'd0; i_Ena = 1'b0;
        step(3);
        check("rst_en", w_En, 4'hF);
        check("rst_dir", w_Dir, 0);
        check("rst_cycles", w_Cycles, 0);
        check("rst_busy", w_Busy, 0);
        check("rst_err", w_Err, 0);
        check("rst_count", w_Count, 0);
        rst_n = 1'b1;
        step(2);

        // Motor 2 forward 128 deg -> 71 cycles, 284 clocks
        push_run(4'b1101, 1'b0, 10'd71, 284, 1, 3);
        cmd(2, 12, 128, 3);
        wait_done("t1_done", 400);
        check("t1_cycles_hold", w_Cycles, 71);
        check("t1_en_off", w_En, 4'hF);

        // Motor 1 backward 87 deg -> 48 cycles, 192 clocks
        push_run(4'b1110, 1'b1, 10'd48, 192, 1, 3);
        cmd(1, 13, 87, 2);
        wait_done("t2_done", 300);
        check("t2_dir_hold", w_Dir, 1);

        // Largest legal angle: 360 deg -> 199 cycles
        push_run(4'b1011, 1'b0, 10'd199, 796, 1, 3);
        cmd(3, 12, 360, 3);
        wait_done("t360_done", 900);

        // Rejections
        e0 = err_cnt; cmd(3, 13, 400, 3); err_tok_check("err_deg_over", e0);
        check("err_count", w_Count, 0);
        check("err_en", w_En, 4'hF);
        e0 = err_cnt; tok(5); err_tok_check("err_motor5", e0);
        e0 = err_cnt; tok(1); tok(10); tok(12); tok(1); tok(2); tok(3); tok(4);
        err_tok_check("err_4th_digit", e0);
        e0 = err_cnt; tok(1); tok(10); tok(12); tok(11); err_tok_check("err_no_digit", e0);
        e0 = err_cnt; tok(14); err_tok_check("err_invalid", e0);
        check("err_busy", w_Busy, 0);

        // Zero-cycle command: LOAD + gap only, no enable
        cmd(4, 12, 0, 1);
        bc = 0;
        for (int i = 0; i < 20; i++) begin step(1); if (w_Busy) bc++; end
        check("zero_busy_clocks", bc, 3);
        check("zero_cycles", w_Cycles, 0);

        // Six back-to-back commands; sixth hits a full FIFO
        push_run(4'b1110, 1'b0, 10'd49, 196, 1, 3);
        push_run(4'b1101, 1'b1, 10'd11, 44, 2, 4);
        push_run(4'b1011, 1'b0, 10'd4, 16, 2, 4);
        push_run(4'b0111, 1'b1, 10'd2, 8, 2, 4);
        push_run(4'b1110, 1'b1, 10'd1, 4, 2, 4);
        cmd(1, 12, 90, 2);
        cmd(2, 13, 20, 2);
        cmd(3, 12, 9, 1);
        cmd(4, 13, 5, 1);
        cmd(1, 13, 2, 1);
        e0 = err_cnt;
        cmd(2, 12, 3, 1);
        err_tok_check("q_full_err", e0);
        check("q_count_full", w_Count, 4);
        wait_done("q_done", 1000);
        check("q_count_empty", w_Count, 0);

        // Asynchronous reset mid-run with two queued
        cmd(1, 12, 90, 2);
        cmd(2, 12, 5, 1);
        cmd(3, 12, 5, 1);
        step(10);
        check("rr_running_en", w_En, 4'b1110);
        check("rr_count_pre", w_Count, 2);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rr_en_async", w_En, 4'hF);
        check("rr_count_async", w_Count, 0);
        check("rr_busy_async", w_Busy, 0);
        step(3);
        rst_n = 1'b1;
        bc = 0;
        for (int i = 0; i < 300; i++) begin step(1); if (w_Busy) bc++; end
        check("rr_busy_after", bc, 0);
        check("rr_count_after", w_Count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stpm_cmd_sched.md
Name: stpm_cmd_sched

Overview:
- Command parser and scheduler placed in front of stpm_full.
- Accepts keypad decoder tokens: motor number, SPACE, FORWARD/BACKWARD, 1-3 angle digits, ENTER.
- Converts each command to a motor select, direction and cycle count, and queues it in a small FIFO.
- Sequences commands one at a time onto stpm_full's i_En/i_Dir/i_Cycles, holding each enable for a timed run window.

Parameters:
- STEP_NUM, 71: cycles-per-degree numerator.
- STEP_SHIFT, 7: cycles = (deg*STEP_NUM)>>STEP_SHIFT.
- MAX_DEG, 360: largest accepted angle.
- TICKS_PER_CYCLE, 1000: clocks of enable per motor cycle.
- GAP_TICKS, 100: idle clocks (all enables off) between commands.
- FIFO_DEPTH, 4: queued commands; power of two.

Ports:
- i_Clk  in  1  system clock.
- i_Rst  in  1  asynchronous, active-low reset.
- i_Data  in  4  token; 0-9 digit, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14 INVALID.
- i_Ena  in  1  one-clock strobe; i_Data valid.
- o_Dir  out  1  to stpm_full i_Dir; 0 forward, 1 backward.
- o_En  out  4  to stpm_full i_En; active-low; bit k=0 runs motor k+1.
- o_Cycles  out  10  to stpm_full i_Cycles.
- o_Busy  out  1  sequencer not in S_IDLE.
- o_Err  out  1  one-clock pulse on rejected token/command.
- o_Count  out  3  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (async, i_Rst=0): o_En=4'b1111, o_Dir=0, o_Cycles=0, o_Busy=0, o_Err=0, o_Count=0. Both FSMs go to idle and the FIFO is flushed.
- Parser FSM. Only acts on i_Ena=1.
  - P_MOTOR: digit 1-4 latches motor, then P_SEP.
  - P_SEP: SPACE goes to P_DIR.
  - P_DIR: FORWARD or BACKWARD latches dir and clears deg, then P_DEG.
  - P_DEG: a digit does deg=deg*10+d, up to 3 digits. ENTER with at least 1 digit and deg<=MAX_DEG pushes {motor,dir,cycles}, then P_MOTOR.
  - Any other token in any state, a 4th digit, ENTER with no digits, or deg>MAX_DEG: o_Err pulses next clock, no push, return to P_MOTOR.
- Arithmetic: deg is 10 bits. The product is 18 bits, shifted right by STEP_SHIFT, truncated to 10 bits. Cycles are computed at push time.
- FIFO push on ENTER when full: command dropped and o_Err pulses.
- Simultaneous push and pop while full: both succeed, count unchanged.
- Sequencer FSM:
  - S_IDLE: if FIFO is non-empty, pop and go to S_LOAD.
  - S_LOAD (1 clock): drive o_Dir/o_Cycles from the entry with o_En=1111.
    - If cycles==0, go to S_GAP without enabling.
    - Else go to S_RUN with timer=cycles*TICKS_PER_CYCLE.
  - S_RUN: o_En has the selected bit low. The timer decrements each clock; at 1, go to S_GAP.
  - S_GAP: o_En=1111 for GAP_TICKS clocks, then S_IDLE. o_Dir/o_Cycles hold their last values.
- Latency: ENTER strobe at clock t gives the entry visible at t+1, S_LOAD at t+2, and o_En asserted from t+3 for exactly cycles*TICKS_PER_CYCLE clocks.
- Parser accepts tokens during S_RUN/S_GAP; no backpressure.
- Reset mid-run: o_En returns to 1111 immediately (async), and pending commands are lost.

Optional Feature:
STPM_CMD_ABORT_EN
- Defined: token 14 (INVALID) is an abort, accepted in any parser state. It flushes the FIFO, resets the parser to P_MOTOR, and forces the sequencer from S_RUN/S_LOAD to S_GAP (o_En=1111 next clock). o_Err does not pulse on abort.
- Undefined: token 14 is an ordinary illegal token that pulses o_Err and resets the parser only; the running command completes.

Test Plan (TICKS_PER_CYCLE=4, GAP_TICKS=2):
- Tokens 2,SPACE,FORWARD,1,2,8,ENTER -> o_Cycles=71, o_Dir=0, o_En=4'b1101 for exactly 284 clocks starting 3 clocks after ENTER, then 1111; o_Busy falls after gap.
- Tokens 1,SPACE,BACKWARD,8,7,ENTER -> o_Cycles=48, o_Dir=1, o_En=4'b1110 for 192 clocks.
- Tokens 3,SPACE,BACKWARD,4,0,0,ENTER -> single o_Err pulse, o_Count stays 0, o_En stays 1111; then motor token 5 -> o_Err pulse.
- Six valid commands back-to-back while idle -> first runs, o_Count reaches 4, sixth gives o_Err; five runs execute in order with 2-clock gaps between.
- Tokens 4,SPACE,FORWARD,0,ENTER -> no enable asserted, o_Busy high for LOAD+gap (3 clocks) only.
- i_Rst low mid-S_RUN with 2 queued -> o_En=1111 and o_Count=0 without waiting for a clock edge; after release, o_Busy stays 0.
